// File: rtl/seq_mult_ctrl_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding
// and the default operand width.
package seq_mult_ctrl_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build ripple-carry adders.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/mult_add_cout.sv
// WIDTH-bit ripple adder with carry-in tied to zero and a true carry-out,
// built from full_adder cells.
module mult_add_cout #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a    (x[i]),
            .b    (y[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_mult_ctrl.sv
// Multi-cycle unsigned shift-add multiplier: one WIDTH-bit adder reused over
// WIDTH iterations, with a start/busy/done handshake to the ALU output mux.
//
// state | meaning
// IDLE  | waiting for start; start captures a/b into M/Q
// RUN   | one add/shift iteration per cycle, WIDTH cycles
// DONE  | final cycle; product/done register on exit, start accepted here too
module seq_mult_ctrl
    import seq_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   m_reg;
    // Low WIDTH bits of the WIDTH+1-bit accumulator; its top bit is always
    // zero after the shift, so it is not stored.
    logic [WIDTH-1:0]   acc_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic               accept;
    logic               run_step;
    logic               finish;
    logic               last_iter;

    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign addend    = q_reg[0] ? m_reg : '0;

    mult_add_cout #(.WIDTH(WIDTH)) u_add (
        .x    (acc_reg),
        .y    (addend),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = last_iter ? DONE : RUN;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == RUN);
        run_step = (state == RUN);
        finish   = (state == DONE);
        accept   = start && (state == IDLE || state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reg   <= '0;
            acc_reg <= '0;
            q_reg   <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= finish;
            // Product is taken from the finished job before any new operands load.
            if (finish) begin
                product <= {acc_reg, q_reg};
            end
            if (accept) begin
                m_reg   <= a;
                acc_reg <= '0;
                q_reg   <= b;
                cnt     <= '0;
            end else if (run_step) begin
                acc_reg <= {cout, sum[WIDTH-1:1]};
                q_reg   <= {sum[0], q_reg[WIDTH-1:1]};
                cnt     <= cnt + 1'b1;
            end
        end
    end

endmodule
